// File: rtl/sample_push_arbiter_pkg.sv
// Shared types and helpers for the sample push arbiter and its round-robin picker.
package sample_arb_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic {
    ARB = 1'b0,
    GAP = 1'b1
  } arb_state_t;

  // Source index width; a single bit is kept even for degenerate requester counts.
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int SRC_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] last_ptr,
  output logic [N-1:0]     grant,
  output logic [SRC_W-1:0] winner,
  output logic             any_valid
);

  // Offsets 1..N visit every requester once, ending on last_ptr itself.
  always_comb begin
    int idx;
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_ptr) + k) % N;
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant[idx] = 1'b1;
        winner     = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sample_push_arbiter.sv
// Round-robin arbiter sharing one registered push port between NUM_REQ requesters,
// with an optional forced idle gap after each grant.
module sample_push_arbiter
  import sample_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 0,
  localparam int SRC_W     = src_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          push_valid,
  output logic [DATA_WIDTH-1:0]         push_data,
  output logic [SRC_W-1:0]              push_src,
  output logic [COUNT_W-1:0]            push_count
);

  arb_state_t         state, state_next;
  logic [7:0]         gap_cnt, gap_next;
  logic [SRC_W-1:0]   last_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   winner;
  logic               any_valid;
  logic               fire;

  rr_pick #(
    .N     (NUM_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req       (req_valid),
    .last_ptr  (last_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Grants are suppressed while reset is high so no handshake can slip through.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    req_ready  = '0;
    fire       = 1'b0;
    case (state)
      ARB: begin
        if (!reset && any_valid) begin
          req_ready = grant;
          fire      = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            gap_next   = 8'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        gap_next = gap_cnt - 8'd1;
        if (gap_cnt <= 8'd1) begin
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      gap_cnt    <= '0;
      last_ptr   <= SRC_W'(NUM_REQ - 1);
      push_valid <= 1'b0;
      push_data  <= '0;
      push_src   <= '0;
      push_count <= '0;
    end else begin
      state      <= state_next;
      gap_cnt    <= gap_next;
      push_valid <= fire;
      if (fire) begin
        push_data  <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        push_src   <= winner;
        last_ptr   <= winner;
        push_count <= push_count + COUNT_W'(1);
      end
    end
  end

endmodule
